// File: rtl/alu_mc_pkg.sv
// Shared definitions for the alu_mc block: opcode encodings and FSM state codes.
package alu_mc_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_MUL = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_NOR = 3'b101;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_WIDTH cycles
// after i_start. o_done flags the final iteration cycle and o_product already
// carries that iteration's sum, so the caller can capture it on the same edge.
module alu_mc_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_product
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done     = (r_cnt == CW'(1));
    assign o_product  = w_acc_next;

    // Load operands on start, then consume one multiplier bit per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CW'(DATA_WIDTH);
        end else if (r_cnt != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge; MUL runs through alu_mc_mul when
// ALU_MC_MUL_EN is defined, otherwise MUL completes in one cycle with a zero result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new operation (in_ready = 1)
// BUSY    | iterative multiply in progress
// DONE    | result and flags held until the consumer takes them
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ALUop,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_ovf;
    logic                  r_cout;
    logic                  r_zero;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_ovf;
    logic                  w_cout;
    logic                  w_accept;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign Result    = r_result;
    assign Overflow  = r_ovf;
    assign CarryOut  = r_cout;
    assign Zero      = r_zero;

    assign w_accept = in_valid && in_ready;

    // Extra top bit of w_diff is the unsigned borrow (set iff A < B).
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

`ifdef ALU_MC_MUL_EN
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic [DATA_WIDTH-1:0] w_mul_prod;

    assign w_mul_start = w_accept && (ALUop == ALU_MUL);

    alu_mc_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );
`endif

    // Single-cycle datapath; MUL yields zero here (the iterative path supplies its own result).
    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_cout = 1'b0;
        case (ALUop)
            ALU_AND: w_res = A & B;
            ALU_OR:  w_res = A | B;
            ALU_XOR: w_res = A ^ B;
            ALU_NOR: w_res = ~(A | B);
            ALU_ADD: begin
                w_res  = w_sum[MSB:0];
                w_cout = w_sum[DATA_WIDTH];
                w_ovf  = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            ALU_SUB: begin
                w_res  = w_diff[MSB:0];
                w_cout = w_diff[DATA_WIDTH];
                w_ovf  = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            ALU_SLT: w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: w_res = '0;
        endcase
    end

    // Control FSM and result/flag registers; a reset in any state drops the operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef ALU_MC_MUL_EN
                        if (ALUop == ALU_MUL) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state  <= ST_DONE;
                            r_result <= w_res;
                            r_ovf    <= w_ovf;
                            r_cout   <= w_cout;
                            r_zero   <= (w_res == '0);
                        end
`else
                        r_state  <= ST_DONE;
                        r_result <= w_res;
                        r_ovf    <= w_ovf;
                        r_cout   <= w_cout;
                        r_zero   <= (w_res == '0);
`endif
                    end
                end
                ST_BUSY: begin
`ifdef ALU_MC_MUL_EN
                    if (w_mul_done) begin
                        r_state  <= ST_DONE;
                        r_result <= w_mul_prod;
                        r_ovf    <= 1'b0;
                        r_cout   <= 1'b0;
                        r_zero   <= (w_mul_prod == '0);
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance for the main checks and an 8-bit
// instance for narrow-width boundary cases. Works with or without ALU_MC_MUL_EN.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  ALUop;
    logic [31:0] A, B, Result;
    logic        Overflow, CarryOut, Zero;

    logic        e8_in_valid, e8_in_ready, e8_out_valid, e8_out_ready;
    logic [2:0]  e8_ALUop;
    logic [7:0]  e8_A, e8_B, e8_Result;
    logic        e8_Overflow, e8_CarryOut, e8_Zero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
        .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
    );

    alu_mc #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(e8_in_valid), .in_ready(e8_in_ready), .ALUop(e8_ALUop), .A(e8_A), .B(e8_B),
        .out_valid(e8_out_valid), .out_ready(e8_out_ready), .Result(e8_Result),
        .Overflow(e8_Overflow), .CarryOut(e8_CarryOut), .Zero(e8_Zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one op on the 32-bit instance, then scramble the inputs.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("issue32_ready", in_ready, 1);
        in_valid = 1'b1; ALUop = op; A = a; B = b;
        tick();
        in_valid = 1'b0; ALUop = ~op; A = ~a; B = $urandom;
    endtask

    task automatic expect32(input string tag, input logic [31:0] res, input logic ovf,
                            input logic cout, input logic zero);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"},   Result,    res);
        check({tag, "_ovf"},   Overflow,  ovf);
        check({tag, "_cout"},  CarryOut,  cout);
        check({tag, "_zero"},  Zero,      zero);
    endtask

    task automatic consume32(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 50 && !e8_in_ready; i++) tick();
        check("issue8_ready", e8_in_ready, 1);
        e8_in_valid = 1'b1; e8_ALUop = op; e8_A = a; e8_B = b;
        tick();
        e8_in_valid = 1'b0; e8_ALUop = ~op; e8_A = ~a; e8_B = ~b;
    endtask

    task automatic consume8();
        e8_out_ready = 1'b1;
        tick();
        e8_out_ready = 1'b0;
        check("e8_drained", e8_out_valid, 0);
    endtask

    initial begin
        int   lat;
        logic rdy_seen;
        logic ov_seen;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; ALUop = 3'b000; A = '0; B = '0;
        e8_in_valid = 1'b0; e8_out_ready = 1'b0; e8_ALUop = 3'b000; e8_A = '0; e8_B = '0;

        tick();
        tick();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    Result,    0);
        check("rst_ovf",       Overflow,  0);
        check("rst_cout",      CarryOut,  0);
        check("rst_zero",      Zero,      0);
        rst_n = 1'b1;
        tick();

        // Latency-1 ops: result visible right after the accepting edge.
        issue32(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_ovf_inrdy", in_ready, 0);
        expect32("add_ovf", 32'h8000_0000, 1, 0, 0);
        consume32("add_ovf");
        check("add_ovf_ready_back", in_ready, 1);

        issue32(3'b110, 32'h0000_0000, 32'h0000_0001);
        expect32("sub_borrow", 32'hFFFF_FFFF, 0, 1, 0);
        consume32("sub_borrow");

        issue32(3'b111, 32'h8000_0000, 32'h0000_0001);
        expect32("slt_neg", 32'h0000_0001, 0, 0, 0);
        consume32("slt_neg");

        issue32(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        expect32("slt_ovf", 32'h0000_0000, 0, 0, 1);
        consume32("slt_ovf");

        issue32(3'b110, 32'h8000_0000, 32'h0000_0001);
        expect32("sub_ovf", 32'h7FFF_FFFF, 1, 0, 0);
        consume32("sub_ovf");

        issue32(3'b110, 32'h0000_0005, 32'h0000_0005);
        expect32("sub_zero", 32'h0000_0000, 0, 0, 1);
        consume32("sub_zero");

        issue32(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        expect32("add_carry", 32'h0000_0000, 0, 1, 1);
        consume32("add_carry");

        issue32(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect32("and", 32'hF000_F000, 0, 0, 0);
        consume32("and");
        issue32(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect32("or", 32'hFFF0_FFF0, 0, 0, 0);
        consume32("or");
        issue32(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect32("xor", 32'h0FF0_0FF0, 0, 0, 0);
        consume32("xor");
        issue32(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect32("nor", 32'h000F_000F, 0, 0, 0);
        consume32("nor");

        // Back-pressure: result held, new requests ignored, even on the draining edge.
        issue32(3'b010, 32'h0000_0002, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ALUop = 3'b001; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
            tick();
            check("hold_res",   Result,    32'h0000_0005);
            check("hold_valid", out_valid, 1);
            check("hold_inrdy", in_ready,  0);
            check("hold_flags", {Overflow, CarryOut, Zero}, 3'b000);
        end
        consume32("hold");
        in_valid = 1'b0;
        check("hold_ready_back", in_ready, 1);

`ifdef ALU_MC_MUL_EN
        issue32(3'b011, 32'h0001_0003, 32'h0002_0005);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 45) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        check("mul_latency", lat, 33);
        check("mul_busy_rdy", rdy_seen, 0);
        expect32("mul", 32'h000B_000F, 0, 0, 0);
        consume32("mul");

        // Reset during BUSY cycle 10 must abort with no result ever presented.
        issue32(3'b011, 32'h0001_0003, 32'h0002_0005);
        repeat (9) tick();
        check("abort_busy", {in_ready, out_valid}, 2'b00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", out_valid, 0);
        check("abort_res",   Result,    0);
        check("abort_rdy",   in_ready,  1);
        ov_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen = 1'b1;
            tick();
        end
        check("abort_no_result", ov_seen, 0);
`else
        issue32(3'b011, 32'h0001_0003, 32'h0002_0005);
        expect32("mul_off", 32'h0000_0000, 0, 0, 1);
        consume32("mul_off");
`endif

        // Reset while a result waits in DONE drops it.
        issue32(3'b010, 32'h1111_1111, 32'h2222_2222);
        check("done_before_rst", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_done_valid", out_valid, 0);
        check("rst_done_res",   Result,    0);

        issue32(3'b010, 32'h0000_0002, 32'h0000_0003);
        expect32("post_rst_add", 32'h0000_0005, 0, 0, 0);
        consume32("post_rst_add");

        // Narrow instance boundaries.
        issue8(3'b010, 8'hFF, 8'h01);
        check("e8_add_valid", e8_out_valid, 1);
        check("e8_add_res",   e8_Result,    8'h00);
        check("e8_add_cout",  e8_CarryOut,  1);
        check("e8_add_ovf",   e8_Overflow,  0);
        check("e8_add_zero",  e8_Zero,      1);
        consume8();

        issue8(3'b010, 8'h7F, 8'h01);
        check("e8_addovf_res", e8_Result,   8'h80);
        check("e8_addovf_ovf", e8_Overflow, 1);
        consume8();

        issue8(3'b011, 8'h10, 8'h10);
        lat = 1;
        while (!e8_out_valid && lat < 20) begin
            tick();
            lat++;
        end
`ifdef ALU_MC_MUL_EN
        check("e8_mul_latency", lat, 9);
`else
        check("e8_mul_latency", lat, 1);
`endif
        check("e8_mul_res",  e8_Result, 8'h00);
        check("e8_mul_zero", e8_Zero,   1);
        consume8();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width (legal values 8..64).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  operation request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port ALUop  input  3  opcode, sampled on input handshake.
REQ-007 The block SHALL have ports A, B  input  DATA_WIDTH  operands, sampled on input handshake.
REQ-008 The block SHALL have port out_valid  output  1  result valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port Result  output  DATA_WIDTH  registered result.
REQ-011 The block SHALL have ports Overflow, CarryOut, Zero  output  1 each  registered flags.

Function
REQ-012 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 100 XOR, 101 NOR, 011 MUL (low DATA_WIDTH bits of unsigned product).
REQ-013 Input handshake SHALL occur on a cycle with in_valid && in_ready; output handshake on out_valid && out_ready.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE + handshake, non-MUL op: next state DONE, outputs registered in that same edge (latency 1).
REQ-016 IDLE + handshake, MUL: next state BUSY; shift-add iteration, one multiplier bit per cycle; after DATA_WIDTH BUSY cycles go to DONE (latency DATA_WIDTH+1).
REQ-017 DONE SHALL hold Result and flags stable until out_ready; on output handshake go to IDLE.
REQ-018 No new operation SHALL be accepted in the same cycle as the output handshake (in_ready is 0 in DONE).
REQ-019 ADD: CarryOut = carry out of MSB; Overflow = signed overflow of A+B.
REQ-020 SUB: CarryOut = 1 iff A < B unsigned (borrow); Overflow = signed overflow of A-B.
REQ-021 For ops other than ADD/SUB, Overflow and CarryOut SHALL be 0.
REQ-022 Zero SHALL be 1 iff Result == 0, for every op.
REQ-023 SLT: Result = {DATA_WIDTH-1 zeros, (A<B signed)}, correct including overflowing A-B.
REQ-024 In-flight inputs changing on A/B/ALUop after handshake SHALL not affect the result.

Reset
REQ-025 On rst_n low at posedge: state IDLE, in_ready 1 from next cycle, out_valid 0, Result 0, Overflow 0, CarryOut 0, Zero 0.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-027 Macro ALU_MC_MUL_EN: defined -> MUL implemented per REQ-016.
REQ-028 Without ALU_MC_MUL_EN: opcode 011 SHALL complete with latency 1, Result 0, Zero 1, BUSY unreachable, multiplier logic absent.

Structure
REQ-029 Package alu_mc_pkg SHALL hold opcode constants (ALU_AND..ALU_MUL) and the FSM state encoding.
REQ-030 The iterative multiplier SHALL be sub-module alu_mc_mul (start, operands, done, product), parametrised by DATA_WIDTH.

Verification
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> one cycle after handshake out_valid=1, Result 0x80000000, Overflow 1, CarryOut 0, Zero 0.
REQ-032 SUB 0x00000000 - 0x00000001 -> Result 0xFFFFFFFF, CarryOut 1, Overflow 0; SLT 0x80000000 vs 0x00000001 -> Result 1.
REQ-033 MUL 0x00010003 * 0x00020005 (MUL_EN) -> out_valid exactly 33 cycles after handshake, Result 0x000B000F, in_ready 0 throughout.
REQ-034 out_ready held 0 for 5 cycles in DONE -> Result/flags unchanged, in_ready 0; in_valid pulses ignored.
REQ-035 rst_n low in BUSY cycle 10 of MUL -> next cycle IDLE, out_valid 0, Result 0; following ADD 2+3 yields 5.
REQ-036 DATA_WIDTH=8 build: ADD 0xFF+0x01 -> Result 0x00, CarryOut 1, Zero 1; MUL 0x10*0x10 -> Result 0x00 after 9 cycles.
